rf_write_port_arbiter: RTL and testbench

- Shares the single register-file write port between the in-order write-back stage and a multi-cycle execution unit (mul/div) that returns results out of band.
- Write-back always has priority. Multi-cycle results are buffered in a small in-order queue and drained into idle write-port cycles.
- Buffered results are squashed when a younger write-back targets the same rd.
- A starvation counter raises a stall request so the pipeline frees a write slot.
- Sits between WriteBackStage/MemoryAccessStage outputs and the RegisterFile write port.

---
 rtl/rf_write_port_arbiter.sv | 127 ++++++++++++
 tb/tb_rf_write_port_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_port_arbiter.sv
// Shares the register-file write port between write-back (priority) and a
// multi-cycle unit whose results are queued and drained into idle slots.
module rf_write_port_arbiter #(
   parameter int XLEN         = 32,
   parameter int REG_ADDR_W   = 5,
   parameter int BUF_DEPTH    = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wb_valid,
   input  logic [REG_ADDR_W-1:0]         wb_rd,
   input  logic [XLEN-1:0]               wb_data,
   input  logic                          mc_valid,
   output logic                          mc_ready,
   input  logic [REG_ADDR_W-1:0]         mc_rd,
   input  logic [XLEN-1:0]               mc_data,
   output logic                          rf_we,
   output logic [REG_ADDR_W-1:0]         rf_rd,
   output logic [XLEN-1:0]               rf_data,
   output logic                          stall_req,
   output logic [$clog2(BUF_DEPTH):0]    buf_count
);

   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);

   logic [REG_ADDR_W-1:0] q_rd   [BUF_DEPTH];
   logic [XLEN-1:0]       q_data [BUF_DEPTH];
   logic [BUF_DEPTH-1:0]  q_vld;
   logic [PTR_W-1:0]      head;
   logic [PTR_W-1:0]      tail;
   logic [CNT_W-1:0]      count;
   logic [STV_W-1:0]      starve_cnt;
   logic [STV_W-1:0]      starve_nxt;

   logic wb_hit;
   logic slot_free;
   logic not_empty;
   logic head_vld;
   logic accept;
   logic bypass;
   logic push;
   logic push_vld;
   logic pop;

   assign wb_hit    = wb_valid && (wb_rd != '0);
   assign slot_free = !wb_hit;
   assign not_empty = (count != '0);
   assign head_vld  = q_vld[head];

   assign mc_ready  = (count < CNT_W'(BUF_DEPTH)) && !rst;
   assign accept    = mc_valid && mc_ready;
   assign bypass    = accept && !not_empty && slot_free;
   assign push      = accept && !bypass;
   // Write-back is younger, so a same-cycle match makes the mc result dead on arrival.
   assign push_vld  = (mc_rd != '0) && !(wb_hit && (mc_rd == wb_rd));
   assign pop       = !rst && slot_free && not_empty;

   assign buf_count = rst ? '0 : count;

   always_comb begin
      rf_we   = 1'b0;
      rf_rd   = '0;
      rf_data = '0;
      if (!rst) begin
         if (wb_hit) begin
            rf_we   = 1'b1;
            rf_rd   = wb_rd;
            rf_data = wb_data;
         end else if (not_empty) begin
            if (head_vld) begin
               rf_we   = 1'b1;
               rf_rd   = q_rd[head];
               rf_data = q_data[head];
            end
         end else if (bypass && (mc_rd != '0)) begin
            rf_we   = 1'b1;
            rf_rd   = mc_rd;
            rf_data = mc_data;
         end
      end
   end

   always_comb begin
      starve_nxt = starve_cnt;
      if (pop || !not_empty) begin
         starve_nxt = '0;
      end else if (head_vld && wb_hit && (starve_cnt != STV_W'(STARVE_LIMIT))) begin
         starve_nxt = starve_cnt + STV_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         q_vld      <= '0;
         starve_cnt <= '0;
         stall_req  <= 1'b0;
      end else begin
         if (wb_hit) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
               if (q_rd[i] == wb_rd) begin
                  q_vld[i] <= 1'b0;
               end
            end
         end
         if (push) begin
            q_rd[tail]   <= mc_rd;
            q_data[tail] <= mc_data;
            q_vld[tail]  <= push_vld;
            tail         <= tail + PTR_W'(1);
         end
         if (pop) begin
            head <= head + PTR_W'(1);
         end
         count      <= count + CNT_W'(push) - CNT_W'(pop);
         starve_cnt <= starve_nxt;
         // Counter drops to zero on the pop edge, which also releases the stall.
         stall_req  <= (starve_nxt == STV_W'(STARVE_LIMIT));
      end
   end

endmodule

// File: tb/tb_rf_write_port_arbiter.sv
// Scoreboard bench for rf_write_port_arbiter: expected mc writes are queued on
// acceptance, squashed by younger write-backs, and matched against rf writes.
module tb_rf_write_port_arbiter;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } wr_t;

   logic        clk;
   logic        rst;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        mc_valid;
   logic        mc_ready;
   logic [4:0]  mc_rd;
   logic [31:0] mc_data;
   logic        rf_we;
   logic [4:0]  rf_rd;
   logic [31:0] rf_data;
   logic        stall_req;
   logic [1:0]  buf_count;

   logic        s_we;
   logic [4:0]  s_rd;
   logic [31:0] s_data;
   logic        s_ready;
   logic        s_stall;
   logic [1:0]  s_count;

   wr_t         exp_q[$];
   logic [31:0] shadow [32];
   int          checks;
   int          failures;

   rf_write_port_arbiter #(
      .XLEN(32), .REG_ADDR_W(5), .BUF_DEPTH(2), .STARVE_LIMIT(4)
   ) dut (
      .clk(clk), .rst(rst),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_rd(mc_rd), .mc_data(mc_data),
      .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data),
      .stall_req(stall_req), .buf_count(buf_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
      end
   endtask

   // Drives one cycle, samples mid-cycle and settles the scoreboard before the edge.
   task automatic applyStimulus(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                                input logic mv, input logic [4:0] mr, input logic [31:0] md);
      wr_t item;
      wb_valid = wv; wb_rd = wr; wb_data = wd;
      mc_valid = mv; mc_rd = mr; mc_data = md;
      @(negedge clk);
      s_we = rf_we; s_rd = rf_rd; s_data = rf_data;
      s_ready = mc_ready; s_stall = stall_req; s_count = buf_count;
      if (mv && s_ready && (mr != 5'd0) && !(wv && (wr != 5'd0) && (wr == mr))) begin
         item.rd = mr;
         item.data = md;
         exp_q.push_back(item);
      end
      if (wv && (wr != 5'd0)) begin
         checkOutput("wb_we", s_we, 1);
         checkOutput("wb_rd", s_rd, wr);
         checkOutput("wb_data", s_data, wd);
      end else if (s_we) begin
         if (exp_q.size() == 0) begin
            checkOutput("spurious_we", s_we, 0);
         end else begin
            item = exp_q.pop_front();
            checkOutput("mc_rd", s_rd, item.rd);
            checkOutput("mc_data", s_data, item.data);
         end
      end
      if (s_we) shadow[s_rd] = s_data;
      if (wv && (wr != 5'd0)) begin
         for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].rd == wr) exp_q.delete(i);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      checks = 0;
      failures = 0;
      for (int i = 0; i < 32; i++) shadow[i] = 32'd0;
      rst = 1'b1;
      wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
      mc_valid = 1'b0; mc_rd = '0; mc_data = '0;
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h55);
      checkOutput("rst_we", s_we, 0);
      checkOutput("rst_rd", s_rd, 0);
      checkOutput("rst_data", s_data, 0);
      checkOutput("rst_ready", s_ready, 0);
      checkOutput("rst_count", s_count, 0);
      checkOutput("rst_stall", s_stall, 0);
      rst = 1'b0;

      // Idle bypass
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hA5);
      checkOutput("bypass_we", s_we, 1);
      checkOutput("bypass_count", s_count, 0);
      idleCycle();
      checkOutput("bypass_count_after", s_count, 0);

      // Conflict queueing and drain
      applyStimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h77);
      checkOutput("cq_ready0", s_ready, 1);
      applyStimulus(1'b1, 5'd3, 32'h34, 1'b1, 5'd8, 32'h88);
      checkOutput("cq_count1", s_count, 1);
      applyStimulus(1'b1, 5'd3, 32'h35, 1'b1, 5'd10, 32'hAA);
      checkOutput("cq_full_ready", s_ready, 0);
      checkOutput("cq_count2", s_count, 2);
      idleCycle();
      checkOutput("drain7_we", s_we, 1);
      checkOutput("drain_count2", s_count, 2);
      idleCycle();
      checkOutput("drain8_we", s_we, 1);
      checkOutput("drain_count1", s_count, 1);
      idleCycle();
      checkOutput("drain_count0", s_count, 0);
      checkOutput("drain_done_we", s_we, 0);

      // Squash by younger write-back
      applyStimulus(1'b1, 5'd3, 32'h01, 1'b1, 5'd9, 32'h99);
      applyStimulus(1'b1, 5'd9, 32'h11, 1'b0, 5'd0, 32'd0);
      idleCycle();
      checkOutput("squash_pop_we", s_we, 0);
      checkOutput("squash_pop_count", s_count, 1);
      idleCycle();
      checkOutput("squash_done_count", s_count, 0);

      // Same-cycle squash
      applyStimulus(1'b1, 5'd2, 32'h22, 1'b1, 5'd6, 32'h66);
      applyStimulus(1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 32'h4F);
      checkOutput("same_count1", s_count, 1);
      checkOutput("same_ready", s_ready, 1);
      idleCycle();
      checkOutput("same_write6", s_we, 1);
      idleCycle();
      checkOutput("same_dead_we", s_we, 0);
      checkOutput("same_dead_count", s_count, 1);
      idleCycle();
      checkOutput("same_done_count", s_count, 0);

      // Starvation
      applyStimulus(1'b1, 5'd1, 32'h10, 1'b1, 5'd12, 32'hC0);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 5'd1, 32'h20 + i, 1'b0, 5'd0, 32'd0);
         checkOutput("starve_stall", s_stall, (i >= 4));
      end
      idleCycle();
      checkOutput("starve_pop_we", s_we, 1);
      checkOutput("starve_pop_stall", s_stall, 1);
      idleCycle();
      checkOutput("starve_release", s_stall, 0);
      checkOutput("starve_count", s_count, 0);

      // x0 handling
      applyStimulus(1'b1, 5'd2, 32'h20, 1'b1, 5'd13, 32'hD0);
      applyStimulus(1'b1, 5'd0, 32'h99, 1'b0, 5'd0, 32'd0);
      checkOutput("x0_wb_drain_we", s_we, 1);
      checkOutput("x0_wb_drain_rd", s_rd, 13);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hEE);
      checkOutput("x0_bypass_drop", s_we, 0);
      applyStimulus(1'b1, 5'd2, 32'h21, 1'b1, 5'd0, 32'hEF);
      idleCycle();
      checkOutput("x0_queued_we", s_we, 0);
      checkOutput("x0_queued_count", s_count, 1);
      idleCycle();
      checkOutput("x0_done_count", s_count, 0);

      // Reset with a full queue
      applyStimulus(1'b1, 5'd3, 32'h36, 1'b1, 5'd14, 32'hE1);
      applyStimulus(1'b1, 5'd3, 32'h37, 1'b1, 5'd15, 32'hF1);
      rst = 1'b1;
      idleCycle();
      checkOutput("midrst_we", s_we, 0);
      checkOutput("midrst_count", s_count, 0);
      rst = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 4; i++) begin
         idleCycle();
         checkOutput("postrst_we", s_we, 0);
         checkOutput("postrst_count", s_count, 0);
      end

      checkOutput("reg9_value", shadow[9], 32'h11);
      checkOutput("reg4_value", shadow[4], 32'h44);
      checkOutput("exp_q_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
